// File: rtl/counter_4bit_pkg.sv
// Shared defaults for the counter_4bit timebase.
package counter_4bit_pkg;

    // Default counter width; instances may override within 1..32.
    localparam int unsigned DefaultWidth = 4;

    // Legal width range, kept here so integrators can check overrides.
    localparam int unsigned MinWidth = 1;
    localparam int unsigned MaxWidth = 32;

endpackage

// File: rtl/counter_4bit.sv
// Free-running binary up-counter with terminal-count flag and wrap pulse.
// Reset is synchronous and active-high on the legacy-named rstn port.
module counter_4bit
    import counter_4bit_pkg::*;
#(
    parameter int unsigned     WIDTH   = DefaultWidth,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;

    // Count and wrap state: synchronous reset, otherwise increment mod 2**WIDTH.
    always_ff @(posedge clk) begin
        if (rstn) begin
            count_q <= RST_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_q + WIDTH'(1);
            // Flag the cycle that shows 0 after rolling over from MAX.
            wrap_q  <= (count_q == MAX);
        end
    end

    // Outputs: tc decodes the registered count directly, no extra stage.
    always_comb begin
        count_out = count_q;
        tc        = (count_q == MAX);
        wrap      = wrap_q;
    end

endmodule

// File: tb/tb_counter_4bit.sv
// Self-checking bench for counter_4bit using an expected-value scoreboard.
module tb_counter_4bit;

    localparam int W    = 4;
    localparam int MaxV = 15;

    logic         clk  = 1'b0;
    logic         rstn = 1'b1;
    logic [W-1:0] count_out;
    logic         tc;
    logic         wrap;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         wrap;
    } exp_t;

    exp_t sb_q[$];

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   model_cnt  = 0;
    logic model_wrap = 1'b0;
    int   wrap_seen  = 0;
    int   tc_seen    = 0;

    counter_4bit #(
        .WIDTH   (W),
        .RST_VAL (4'd0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .count_out (count_out),
        .tc        (tc),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // One clock edge: drive rstn, update the model at the edge, compare 1 ns later.
    task automatic step(input logic r, input string tag);
        exp_t e;
        rstn = r;
        @(posedge clk);
        if (r) begin
            model_cnt  = 0;
            model_wrap = 1'b0;
        end else begin
            model_wrap = (model_cnt == MaxV);
            model_cnt  = (model_cnt + 1) % 16;
        end
        e.cnt  = model_cnt[W-1:0];
        e.tc   = (model_cnt == MaxV);
        e.wrap = model_wrap;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check_val({tag, ".cnt"},  32'(count_out), 32'(e.cnt));
        check_val({tag, ".tc"},   32'(tc),        32'(e.tc));
        check_val({tag, ".wrap"}, 32'(wrap),      32'(e.wrap));
        if (wrap === 1'b1) wrap_seen++;
        if (tc === 1'b1) tc_seen++;
    endtask

    initial begin
        // T1: reset held for two edges
        step(1'b1, "t1.rst0");
        step(1'b1, "t1.rst1");

        // T2: ten edges after release count 1..10
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, "t2.cnt");
            check_val("t2.seq", 32'(count_out), 32'(i));
        end

        // T3: reach 15, then wrap to 0 with pulse, then 1 without
        for (int i = 11; i <= 15; i++) step(1'b0, "t3.up");
        check_val("t3.tc_at_max", 32'(tc), 32'd1);
        step(1'b0, "t3.wrap");
        check_val("t3.wrap_pulse", 32'(wrap), 32'd1);
        step(1'b0, "t3.after");
        check_val("t3.wrap_clear", 32'(wrap), 32'd0);

        // T4: 30 edges after release, exactly one tc and one wrap
        step(1'b1, "t4.rst");
        wrap_seen = 0;
        tc_seen   = 0;
        for (int i = 0; i < 30; i++) step(1'b0, "t4.run");
        check_val("t4.wrap_count", 32'(wrap_seen), 32'd1);
        check_val("t4.tc_count",   32'(tc_seen),   32'd1);
        check_val("t4.final_cnt",  32'(count_out), 32'd14);

        // T5: reset at count 7, hold, then resume
        step(1'b1, "t5.rst");
        for (int i = 0; i < 7; i++) step(1'b0, "t5.up");
        check_val("t5.at7", 32'(count_out), 32'd7);
        for (int i = 0; i < 3; i++) step(1'b1, "t5.hold");
        check_val("t5.held", 32'(count_out), 32'd0);
        step(1'b0, "t5.resume1");
        step(1'b0, "t5.resume2");
        check_val("t5.resumed", 32'(count_out), 32'd2);

        // T6: reset while at max -> 0 with no wrap pulse
        for (int i = 3; i <= 15; i++) step(1'b0, "t6.up");
        check_val("t6.at_max", 32'(count_out), 32'd15);
        step(1'b1, "t6.rst_max");
        check_val("t6.no_wrap", 32'(wrap), 32'd0);
        step(1'b0, "t6.resume");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
